// File: rtl/exu_lsu_pkg.sv
// ---------------------------------------------------------------------------
// exu_lsu_pkg : op codes, FSM encoding and helpers shared by the LSU files
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package exu_lsu_pkg;

    localparam int LSU_OP_WIDTH    = 4;
    localparam int LSU_STATE_WIDTH = 2;

    localparam logic [LSU_OP_WIDTH-1:0] LSU_NONE = 4'd0;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_LB   = 4'd1;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_LH   = 4'd2;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_LW   = 4'd3;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_LBU  = 4'd4;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_LHU  = 4'd5;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_SB   = 4'd6;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_SH   = 4'd7;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_SW   = 4'd8;

    typedef enum logic [LSU_STATE_WIDTH-1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic lsu_is_store(input logic [LSU_OP_WIDTH-1:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/exu_lsu_if.sv
// ---------------------------------------------------------------------------
// exu_lsu_if : data-memory request/response port of the load/store unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface exu_lsu_if #(
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wmask;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_data
    );
endinterface

`default_nettype wire

// File: rtl/exu_lsu_align.sv
// ---------------------------------------------------------------------------
// exu_lsu_align : byte-lane steering, load extension and access legality check
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exu_lsu_align
    import exu_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic [LSU_OP_WIDTH-1:0] i_op,
    input  logic [1:0]              i_addr_lo,
    input  logic [DATA_W-1:0]       i_wdata,
    input  logic [DATA_W-1:0]       i_resp,
    output logic [STRB_W-1:0]       o_wmask,
    output logic [DATA_W-1:0]       o_wdata,
    output logic [DATA_W-1:0]       o_rdata,
    output logic                    o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_resp[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_resp[16 +: 16] : i_resp[0 +: 16];

    // Reserved codes fall into default and flag an error with no lanes enabled.
    always_comb begin
        o_wmask = '0;
        o_wdata = '0;
        o_rdata = '0;
        o_err   = 1'b0;
        case (i_op)
            LSU_NONE: ;
            LSU_LB:   o_rdata = {{(DATA_W-8){w_byte[7]}}, w_byte};
            LSU_LBU:  o_rdata = {{(DATA_W-8){1'b0}}, w_byte};
            LSU_LH: begin
                o_err   = i_addr_lo[0];
                o_rdata = {{(DATA_W-16){w_half[15]}}, w_half};
            end
            LSU_LHU: begin
                o_err   = i_addr_lo[0];
                o_rdata = {{(DATA_W-16){1'b0}}, w_half};
            end
            LSU_LW: begin
                o_err   = |i_addr_lo;
                o_rdata = i_resp;
            end
            LSU_SB: begin
                o_wmask = STRB_W'(1) << i_addr_lo;
                o_wdata = {STRB_W{i_wdata[7:0]}};
            end
            LSU_SH: begin
                o_err   = i_addr_lo[0];
                o_wmask = i_addr_lo[1] ? STRB_W'(4'b1100) : STRB_W'(4'b0011);
                o_wdata = {(STRB_W/2){i_wdata[15:0]}};
            end
            LSU_SW: begin
                o_err   = |i_addr_lo;
                o_wmask = '1;
                o_wdata = i_wdata;
            end
            default:  o_err = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/exu_lsu.sv
// ---------------------------------------------------------------------------
// exu_lsu : single-outstanding load/store unit with request/response memory port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module exu_lsu
    import exu_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [LSU_OP_WIDTH-1:0] i_lsu_op,
    input  logic [DATA_W-1:0]       i_addr,
    input  logic [DATA_W-1:0]       i_wdata,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [DATA_W-1:0]       o_rdata,
    output logic                    o_err,
    exu_lsu_if.master               mem
);

    lsu_state_e              r_state;
    lsu_state_e              w_state_nxt;
    logic [LSU_OP_WIDTH-1:0] r_op;
    logic [DATA_W-1:0]       r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_err;

    logic                    w_idle;
    logic                    w_accept;
    logic                    w_req_valid;
    logic                    w_in_ready;
    logic                    w_out_valid;
    logic [LSU_OP_WIDTH-1:0] w_al_op;
    logic [1:0]              w_al_addr_lo;
    logic [DATA_W-1:0]       w_al_wdata;
    logic [STRB_W-1:0]       w_al_wmask;
    logic [DATA_W-1:0]       w_al_wdata_lane;
    logic [DATA_W-1:0]       w_al_rdata;
    logic                    w_al_err;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = i_in_valid && w_idle;

    // In IDLE the aligner judges the incoming op; afterwards it works off the latched copy.
    assign w_al_op      = w_idle ? i_lsu_op    : r_op;
    assign w_al_addr_lo = w_idle ? i_addr[1:0] : r_addr[1:0];
    assign w_al_wdata   = w_idle ? i_wdata     : r_wdata;

    exu_lsu_align #(
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) u_align (
        .i_op      (w_al_op),
        .i_addr_lo (w_al_addr_lo),
        .i_wdata   (w_al_wdata),
        .i_resp    (mem.resp_data),
        .o_wmask   (w_al_wmask),
        .o_wdata   (w_al_wdata_lane),
        .o_rdata   (w_al_rdata),
        .o_err     (w_al_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_req_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_state_nxt = (w_al_err || (i_lsu_op == LSU_NONE)) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                w_req_valid = 1'b1;
                if (mem.req_ready) w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem.resp_valid) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (i_out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= LSU_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op    <= i_lsu_op;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_rdata <= '0;
                r_err   <= w_al_err;
            end
            if ((r_state == ST_WAIT) && mem.resp_valid) begin
                r_rdata <= w_al_rdata;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_rdata     = r_rdata;
    assign o_err       = r_err;

    // Request fields are forced to zero outside REQ so the bus never shows stale values.
    assign mem.req_valid = w_req_valid;
    assign mem.req_wen   = w_req_valid && lsu_is_store(r_op);
    assign mem.req_addr  = w_req_valid ? {r_addr[DATA_W-1:2], 2'b00} : '0;
    assign mem.req_wdata = w_req_valid ? w_al_wdata_lane : '0;
    assign mem.req_wmask = w_req_valid ? w_al_wmask : '0;

endmodule

`default_nettype wire

// File: tb/tb_exu_lsu.sv
// ---------------------------------------------------------------------------
// tb_exu_lsu : directed table plus randomized ops against a behavioural LSU model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_exu_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  lsu_op = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] rdata;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    exu_lsu_if #(.DATA_W(32)) mem_if ();

    exu_lsu #(.DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_lsu_op    (lsu_op),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_rdata     (rdata),
        .o_err       (err),
        .mem         (mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bus;
        logic        err;
        logic [31:0] baddr;
        logic        wen;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mw;
        int          rl;
        int          ol;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic        bus;
        logic        err;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wmask;
        int          out_cyc;
        int          req_cyc;
        int          hold_bad;
        int          busy_rdy;
        logic        post_rdy;
        logic        timeout;
    } got_t;

    // Behavioural reference: access size, offset and sign rules in plain arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] mw);
        exp_t   e;
        int     size;
        int     off;
        bit     load;
        bit     sgn;
        longint v;
        longint lim;
        e = '{default: 0};
        off = int'(a % 4);
        load = 0;
        sgn = 0;
        case (op)
            4'd0: size = 0;
            4'd1: begin size = 1; load = 1; sgn = 1; end
            4'd2: begin size = 2; load = 1; sgn = 1; end
            4'd3: begin size = 4; load = 1; end
            4'd4: begin size = 1; load = 1; end
            4'd5: begin size = 2; load = 1; end
            4'd6: size = 1;
            4'd7: size = 2;
            4'd8: size = 4;
            default: size = -1;
        endcase
        if (size < 0) e.err = 1;
        else if (size > 0) begin
            if (off % size != 0) e.err = 1;
            else e.bus = 1;
        end
        if (e.bus) begin
            e.baddr = a - 32'(off);
            lim = longint'(1) << (8 * size);
            if (load) begin
                v = (longint'(a - a + mw) >> (8 * off)) % lim;
                if (sgn && v >= lim / 2) v = v - lim;
                e.rdata = 32'(v);
            end else begin
                e.wen   = 1;
                e.wmask = 4'(((1 << size) - 1) << off);
                v = longint'(wd) % lim;
                e.wdata = 32'(v * (size == 1 ? 64'h01010101 : size == 2 ? 64'h00010001 : 64'd1));
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Runs one op with a responsive memory: req_ready after rl stall cycles,
    // a junk response pulse in the handshake cycle, the real one a cycle later.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] mw, input int rl, input int ol, output got_t g);
        int cyc = 0;
        int outw = 0;
        bit done = 0;
        bit resp_pending = 0;
        g = '{default: 0};
        @(negedge clk);
        in_valid = 1'b1;
        lsu_op = op;
        addr = a;
        wdata = wd;
        @(negedge clk);
        in_valid = 1'b0;
        lsu_op = 4'($urandom);
        addr = $urandom;
        wdata = $urandom;
        while (!done && cyc < 64) begin
            cyc++;
            mem_if.req_ready  = 1'b0;
            mem_if.resp_valid = 1'b0;
            mem_if.resp_data  = $urandom;
            out_ready = 1'b0;
            if (in_ready) g.busy_rdy++;
            if (resp_pending) begin
                mem_if.resp_valid = 1'b1;
                mem_if.resp_data  = mw;
                resp_pending = 0;
            end
            if (mem_if.req_valid) begin
                if (g.req_cyc == 0) begin
                    g.bus   = 1'b1;
                    g.addr  = mem_if.req_addr;
                    g.wdata = mem_if.req_wdata;
                    g.wmask = mem_if.req_wmask;
                    g.wen   = mem_if.req_wen;
                end else if ({mem_if.req_addr, mem_if.req_wdata, mem_if.req_wmask, mem_if.req_wen}
                             !== {g.addr, g.wdata, g.wmask, g.wen}) begin
                    g.hold_bad++;
                end
                g.req_cyc++;
                if (g.req_cyc > rl) begin
                    mem_if.req_ready  = 1'b1;
                    mem_if.resp_valid = 1'b1;
                    mem_if.resp_data  = ~mw;
                    resp_pending = 1;
                end
            end
            if (out_valid) begin
                if (outw == 0) begin
                    g.out_cyc = cyc;
                    g.rdata   = rdata;
                    g.err     = err;
                end else if ({rdata, err} !== {g.rdata, g.err}) begin
                    g.hold_bad++;
                end
                outw++;
                if (outw > ol) begin
                    out_ready = 1'b1;
                    done = 1;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        mem_if.req_ready = 1'b0;
        mem_if.resp_valid = 1'b0;
        g.post_rdy = in_ready && !out_valid;
        g.timeout = !done;
        if (!done) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input got_t g, input int rl);
        chk({tag, ".timeout"}, 32'(g.timeout), 32'd0);
        chk({tag, ".bus"}, 32'(g.bus), 32'(e.bus));
        chk({tag, ".err"}, 32'(g.err), 32'(e.err));
        chk({tag, ".rdata"}, g.rdata, e.rdata);
        chk({tag, ".latency"}, 32'(g.out_cyc), e.bus ? 32'(3 + rl) : 32'd1);
        chk({tag, ".held"}, 32'(g.hold_bad), 32'd0);
        chk({tag, ".busy_ready"}, 32'(g.busy_rdy), 32'd0);
        chk({tag, ".ready_after"}, 32'(g.post_rdy), 32'd1);
        if (e.bus) begin
            chk({tag, ".req_addr"}, g.addr, e.baddr);
            chk({tag, ".req_wen"}, 32'(g.wen), 32'(e.wen));
            chk({tag, ".req_wmask"}, 32'(g.wmask), 32'(e.wmask));
            chk({tag, ".req_cycles"}, 32'(g.req_cyc), 32'(rl + 1));
            if (e.wen) chk({tag, ".req_wdata"}, g.wdata, e.wdata);
        end
    endtask

    initial begin
        vec_t  vt[$];
        got_t  g;
        exp_t  e;
        logic [3:0]  rop;
        logic [31:0] ra;
        int          rl;
        int          ol;

        vt.push_back(vec_t'{4'd8,  32'h80000104, 32'hDEADBEEF, 32'h0,        0, 0, exp_t'{1, 0, 32'h80000104, 1, 4'hF, 32'hDEADBEEF, 32'h0}});
        vt.push_back(vec_t'{4'd1,  32'h80000103, 32'h0,        32'h80FF1234, 0, 0, exp_t'{1, 0, 32'h80000100, 0, 4'h0, 32'h0, 32'hFFFFFF80}});
        vt.push_back(vec_t'{4'd4,  32'h80000103, 32'h0,        32'h80FF1234, 0, 0, exp_t'{1, 0, 32'h80000100, 0, 4'h0, 32'h0, 32'h00000080}});
        vt.push_back(vec_t'{4'd7,  32'h80000002, 32'h0000ABCD, 32'h0,        0, 0, exp_t'{1, 0, 32'h80000000, 1, 4'hC, 32'hABCDABCD, 32'h0}});
        vt.push_back(vec_t'{4'd5,  32'h80000002, 32'h0,        32'hABCD0000, 0, 0, exp_t'{1, 0, 32'h80000000, 0, 4'h0, 32'h0, 32'h0000ABCD}});
        vt.push_back(vec_t'{4'd3,  32'h80000006, 32'h0,        32'h11111111, 0, 0, exp_t'{0, 1, 32'h0, 0, 4'h0, 32'h0, 32'h0}});
        vt.push_back(vec_t'{4'd12, 32'h80000006, 32'h0,        32'h11111111, 0, 0, exp_t'{0, 1, 32'h0, 0, 4'h0, 32'h0, 32'h0}});
        vt.push_back(vec_t'{4'd3,  32'h80000008, 32'h0,        32'h12345678, 3, 2, exp_t'{1, 0, 32'h80000008, 0, 4'h0, 32'h0, 32'h12345678}});
        vt.push_back(vec_t'{4'd0,  32'h00000005, 32'h5555AAAA, 32'h0,        0, 0, exp_t'{0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0}});
        vt.push_back(vec_t'{4'd2,  32'h00000012, 32'h0,        32'h80017FFF, 0, 1, exp_t'{1, 0, 32'h00000010, 0, 4'h0, 32'h0, 32'hFFFF8001}});
        vt.push_back(vec_t'{4'd6,  32'h00000021, 32'h123456AB, 32'h0,        1, 0, exp_t'{1, 0, 32'h00000020, 1, 4'h2, 32'hABABABAB, 32'h0}});
        vt.push_back(vec_t'{4'd7,  32'h00000003, 32'hFFFF1234, 32'h0,        0, 0, exp_t'{0, 1, 32'h0, 0, 4'h0, 32'h0, 32'h0}});
        vt.push_back(vec_t'{4'd1,  32'h00000001, 32'h0,        32'h00007F00, 0, 0, exp_t'{1, 0, 32'h00000000, 0, 4'h0, 32'h0, 32'h0000007F}});

        mem_if.req_ready  = 1'b0;
        mem_if.resp_valid = 1'b0;
        mem_if.resp_data  = '0;

        // Inputs toggling under reset must have no effect.
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        lsu_op = 4'd3;
        @(negedge clk);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.req_valid", 32'(mem_if.req_valid), 32'd0);
        chk("reset.req_wmask", 32'(mem_if.req_wmask), 32'd0);
        chk("reset.rdata", rdata, 32'd0);
        chk("reset.err", 32'(err), 32'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;

        foreach (vt[i]) begin
            do_op(vt[i].op, vt[i].addr, vt[i].wd, vt[i].mw, vt[i].rl, vt[i].ol, g);
            compare($sformatf("vec%0d", i), vt[i].e, g, vt[i].rl);
        end

        // Reset while waiting for a response, then a stray response afterwards.
        @(negedge clk);
        in_valid = 1'b1;
        lsu_op = 4'd3;
        addr = 32'h00000040;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort.req_valid", 32'(mem_if.req_valid), 32'd1);
        mem_if.req_ready = 1'b1;
        @(negedge clk);
        mem_if.req_ready = 1'b0;
        chk("abort.waiting", 32'({mem_if.req_valid, out_valid, in_ready}), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.async_in_ready", 32'(in_ready), 32'd1);
        chk("abort.async_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_if.resp_valid = 1'b1;
        mem_if.resp_data  = 32'hBAD0BAD0;
        @(negedge clk);
        mem_if.resp_valid = 1'b0;
        chk("stray.out_valid", 32'(out_valid), 32'd0);
        chk("stray.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("stray.out_valid2", 32'(out_valid), 32'd0);
        do_op(4'd3, 32'h00000080, 32'h0, 32'h0BADCAFE, 0, 0, g);
        compare("after_abort", model(4'd3, 32'h00000080, 32'h0, 32'h0BADCAFE), g, 0);

        for (int n = 0; n < 150; n++) begin
            rop = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            ra  = $urandom;
            rl  = $urandom_range(0, 2);
            ol  = $urandom_range(0, 2);
            e   = model(rop, ra, 32'h0, 32'h0);
            begin
                logic [31:0] rwd;
                logic [31:0] rmw;
                rwd = $urandom;
                rmw = $urandom;
                e = model(rop, ra, rwd, rmw);
                do_op(rop, ra, rwd, rmw, rl, ol, g);
            end
            compare($sformatf("rnd%0d_op%0d", n, rop), e, g, rl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
